// File: rtl/memory_pkg.sv
// Shared definitions for the MEM stage: widths, MemtoReg encoding,
// data-port FSM state type and the two pipeline register layouts.
package memory_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_LO  = 2'b10;
    localparam logic [1:0] MTR_HI  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } dmem_state_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic [1:0]        mem_to_reg;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] write_data;
        logic [DATA_W-1:0] pc_plus4;
    } exmem_t;

    typedef struct packed {
        logic              reg_write;
        logic              jump;
        logic [1:0]        mem_to_reg;
        logic [REG_W-1:0]  write_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] pc_plus4;
    } memwb_t;

    function automatic logic is_word_aligned(input logic [DATA_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/memory_dmem_port.sv
// Data-memory bus master: req/ack handshake FSM, stall and
// misaligned-address detection for the instruction sitting in M.
module dmem_port
    import memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_load,
    input  logic              mem_store,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dmem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              StallM,
    output logic              AdrErrM,
    output logic              load_done
);

    dmem_state_e state_q;
    dmem_state_e state_d;
    logic        mem_op;
    logic        aligned;

    assign mem_op  = mem_load | mem_store;
    assign aligned = is_word_aligned(addr);

    // Address/data come straight from EX/MEM, which is frozen while stalled,
    // so they stay stable for the whole outstanding access.
    assign dmem_req   = (state_q == ST_WAIT) | (mem_op & aligned);
    assign dmem_we    = dmem_req & mem_store;
    assign dmem_addr  = addr;
    assign dmem_wdata = wdata;
    assign StallM     = dmem_req & ~dmem_ack;
    assign AdrErrM    = mem_op & ~aligned;
    assign load_done  = dmem_req & dmem_ack & mem_load;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (StallM)   state_d = ST_WAIT;
            ST_WAIT: if (dmem_ack) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/memory.sv
// MIPS MEM stage: EX/MEM register, data-memory access with stall,
// and MEM/WB register feeding writeback.
module memory
    import memory_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              jumpE,
    input  logic [1:0]        MemtoRegE,
    input  logic [REG_W-1:0]  WriteRegE,
    input  logic [DATA_W-1:0] ALUMultOutE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [DATA_W-1:0] PCPlus4E,
    output logic              RegWriteM,
    output logic [1:0]        MemtoRegM,
    output logic [REG_W-1:0]  WriteRegM,
    output logic [DATA_W-1:0] ALUOutM,
    output logic              StallM,
    output logic              AdrErrM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              RegWriteW,
    output logic              jumpW,
    output logic [1:0]        MemtoRegW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] PCPlus4W
);

    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic   load_done;

    dmem_port u_dmem_port (
        .clk        (clk),
        .rst        (rst),
        .mem_load   (exmem_q.mem_to_reg == MTR_MEM),
        .mem_store  (exmem_q.mem_write),
        .addr       (exmem_q.alu_out),
        .wdata      (exmem_q.write_data),
        .dmem_ack   (dmem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .StallM     (StallM),
        .AdrErrM    (AdrErrM),
        .load_done  (load_done)
    );

    always_comb begin
        exmem_d = exmem_q;
        if (!StallM) begin
            exmem_d.reg_write  = RegWriteE;
            exmem_d.mem_write  = MemWriteE;
            exmem_d.jump       = jumpE;
            exmem_d.mem_to_reg = MemtoRegE;
            exmem_d.write_reg  = WriteRegE;
            exmem_d.alu_out    = ALUMultOutE;
            exmem_d.write_data = WriteDataE;
            exmem_d.pc_plus4   = PCPlus4E;
        end
    end

    // Stall pushes a bubble into W; a faulting access must not write the register file.
    always_comb begin
        memwb_d = memwb_q;
        if (StallM) begin
            memwb_d.reg_write = 1'b0;
            memwb_d.jump      = 1'b0;
        end else begin
            memwb_d.reg_write  = exmem_q.reg_write & ~AdrErrM;
            memwb_d.jump       = exmem_q.jump;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.write_reg  = exmem_q.write_reg;
            memwb_d.alu_out    = exmem_q.alu_out;
            memwb_d.pc_plus4   = exmem_q.pc_plus4;
            if (load_done) memwb_d.read_data = dmem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign RegWriteM = exmem_q.reg_write;
    assign MemtoRegM = exmem_q.mem_to_reg;
    assign WriteRegM = exmem_q.write_reg;
    assign ALUOutM   = exmem_q.alu_out;

    assign RegWriteW = memwb_q.reg_write;
    assign jumpW     = memwb_q.jump;
    assign MemtoRegW = memwb_q.mem_to_reg;
    assign WriteRegW = memwb_q.write_reg;
    assign ReadDataW = memwb_q.read_data;
    assign ALUOutW   = memwb_q.alu_out;
    assign PCPlus4W  = memwb_q.pc_plus4;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the MEM stage: loads, stores, wait states,
// misalignment, spurious ack and reset during an outstanding access.
module tb_memory;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, jumpE;
    logic [1:0]  MemtoRegE;
    logic [4:0]  WriteRegE;
    logic [31:0] ALUMultOutE, WriteDataE, PCPlus4E;
    logic        RegWriteM;
    logic [1:0]  MemtoRegM;
    logic [4:0]  WriteRegM;
    logic [31:0] ALUOutM;
    logic        StallM, AdrErrM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        RegWriteW, jumpW;
    logic [1:0]  MemtoRegW;
    logic [4:0]  WriteRegW;
    logic [31:0] ReadDataW, ALUOutW, PCPlus4W;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .jumpE       (jumpE),
        .MemtoRegE   (MemtoRegE),
        .WriteRegE   (WriteRegE),
        .ALUMultOutE (ALUMultOutE),
        .WriteDataE  (WriteDataE),
        .PCPlus4E    (PCPlus4E),
        .RegWriteM   (RegWriteM),
        .MemtoRegM   (MemtoRegM),
        .WriteRegM   (WriteRegM),
        .ALUOutM     (ALUOutM),
        .StallM      (StallM),
        .AdrErrM     (AdrErrM),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .RegWriteW   (RegWriteW),
        .jumpW       (jumpW),
        .MemtoRegW   (MemtoRegW),
        .WriteRegW   (WriteRegW),
        .ReadDataW   (ReadDataW),
        .ALUOutW     (ALUOutW),
        .PCPlus4W    (PCPlus4W)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic rw, input logic mw, input logic jp, input logic [1:0] mtr,
                           input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] wd,
                           input logic [31:0] pc4);
        RegWriteE   = rw;
        MemWriteE   = mw;
        jumpE       = jp;
        MemtoRegE   = mtr;
        WriteRegE   = wr;
        ALUMultOutE = alu;
        WriteDataE  = wd;
        PCPlus4E    = pc4;
    endtask

    task automatic bubble_e();
        drive_e(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        bubble_e();
        #2;
        check("rst_req",    dmem_req,  0);
        check("rst_stall",  StallM,    0);
        check("rst_adrerr", AdrErrM,   0);
        check("rst_rwW",    RegWriteW, 0);
        check("rst_rdW",    ReadDataW, 0);
        check("rst_pc4W",   PCPlus4W,  0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Zero-wait load
        drive_e(1'b1, 1'b0, 1'b0, 2'b01, 5'd3, 32'h100, 32'h0, 32'h1004);
        tick();
        bubble_e();
        check("zl_req",   dmem_req,  1);
        check("zl_we",    dmem_we,   0);
        check("zl_addr",  dmem_addr, 32'h100);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        check("zl_stall", StallM, 0);
        tick();
        dmem_ack = 1'b0;
        check("zl_rdW",  ReadDataW, 32'hDEADBEEF);
        check("zl_mtrW", MemtoRegW, 2'b01);
        check("zl_rwW",  RegWriteW, 1);
        check("zl_wrW",  WriteRegW, 5'd3);
        check("zl_pc4W", PCPlus4W,  32'h1004);
        tick();

        // Store with 3-cycle ack latency
        drive_e(1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 32'h40, 32'h12345678, 32'h2004);
        tick();
        bubble_e();
        for (int i = 0; i < 3; i++) begin
            check("st_req",   dmem_req,   1);
            check("st_we",    dmem_we,    1);
            check("st_addr",  dmem_addr,  32'h40);
            check("st_wdata", dmem_wdata, 32'h12345678);
            check("st_stall", StallM,     1);
            check("st_rwW",   RegWriteW,  0);
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        check("st_ack_we",    dmem_we,    1);
        check("st_ack_addr",  dmem_addr,  32'h40);
        check("st_ack_wdata", dmem_wdata, 32'h12345678);
        check("st_ack_stall", StallM,     0);
        tick();
        dmem_ack = 1'b0;
        check("st_done_req", dmem_req,  0);
        check("st_done_rwW", RegWriteW, 0);
        check("st_done_rdW", ReadDataW, 32'hDEADBEEF);
        tick();

        // Load with 2-cycle latency, followed by an ALU op held in E
        drive_e(1'b1, 1'b0, 1'b0, 2'b01, 5'd7, 32'h200, 32'h0, 32'h3004);
        tick();
        drive_e(1'b1, 1'b0, 1'b0, 2'b00, 5'd5, 32'h55, 32'h0, 32'h3008);
        check("ld2_stall1", StallM,    1);
        check("ld2_wrM1",   WriteRegM, 5'd7);
        tick();
        check("ld2_stall2", StallM,    1);
        check("ld2_wrM2",   WriteRegM, 5'd7);
        check("ld2_bub1",   RegWriteW, 0);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1;
        check("ld2_stall3", StallM,    0);
        check("ld2_bub2",   RegWriteW, 0);
        tick();
        dmem_ack = 1'b0;
        bubble_e();
        check("ld2_rwW",  RegWriteW, 1);
        check("ld2_wrW",  WriteRegW, 5'd7);
        check("ld2_rdW",  ReadDataW, 32'hCAFEF00D);
        check("ld2_mtrW", MemtoRegW, 2'b01);
        check("alu_wrM",  WriteRegM, 5'd5);
        check("alu_outM", ALUOutM,   32'h55);
        tick();
        check("alu_rwW",  RegWriteW, 1);
        check("alu_wrW",  WriteRegW, 5'd5);
        check("alu_outW", ALUOutW,   32'h55);
        check("alu_mtrW", MemtoRegW, 2'b00);
        check("alu_rdW",  ReadDataW, 32'hCAFEF00D);
        tick();

        // Misaligned load
        drive_e(1'b1, 1'b0, 1'b0, 2'b01, 5'd9, 32'h102, 32'h0, 32'h4004);
        tick();
        bubble_e();
        check("mis_adrerr", AdrErrM,  1);
        check("mis_req",    dmem_req, 0);
        check("mis_stall",  StallM,   0);
        tick();
        check("mis_rwW",     RegWriteW, 0);
        check("mis_adrerr2", AdrErrM,   0);
        check("mis_aluW",    ALUOutW,   32'h102);
        tick();

        // Spurious ack during an ALU op
        drive_e(1'b1, 1'b0, 1'b0, 2'b00, 5'd4, 32'h77, 32'h0, 32'h5004);
        tick();
        bubble_e();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h11111111;
        #1;
        check("sp_req",   dmem_req, 0);
        check("sp_stall", StallM,   0);
        tick();
        dmem_ack = 1'b0;
        check("sp_rdW",  ReadDataW, 32'hCAFEF00D);
        check("sp_rwW",  RegWriteW, 1);
        check("sp_aluW", ALUOutW,   32'h77);
        tick();

        // Back-to-back zero-wait loads: no idle gap
        drive_e(1'b1, 1'b0, 1'b0, 2'b01, 5'd1, 32'h300, 32'h0, 32'h6004);
        dmem_ack = 1'b1;
        tick();
        drive_e(1'b1, 1'b0, 1'b0, 2'b01, 5'd2, 32'h304, 32'h0, 32'h6008);
        dmem_rdata = 32'hA0A0A0A0;
        #1;
        check("b2b_req1",  dmem_req,  1);
        check("b2b_addr1", dmem_addr, 32'h300);
        tick();
        bubble_e();
        dmem_rdata = 32'hB0B0B0B0;
        #1;
        check("b2b_req2",  dmem_req,  1);
        check("b2b_addr2", dmem_addr, 32'h304);
        check("b2b_rdW1",  ReadDataW, 32'hA0A0A0A0);
        tick();
        dmem_ack = 1'b0;
        check("b2b_rdW2", ReadDataW, 32'hB0B0B0B0);
        check("b2b_wrW2", WriteRegW, 5'd2);
        tick();

        // Reset while an access is pending
        drive_e(1'b1, 1'b0, 1'b1, 2'b01, 5'd6, 32'h400, 32'h0, 32'h7004);
        tick();
        bubble_e();
        check("rw_stall_pre", StallM, 1);
        #2;
        rst = 1'b0;
        #1;
        check("rw_req",   dmem_req,  0);
        check("rw_stall", StallM,    0);
        check("rw_rwW",   RegWriteW, 0);
        check("rw_aluW",  ALUOutW,   0);
        tick();
        rst = 1'b1;
        tick();
        check("rw_post_req",   dmem_req,  0);
        check("rw_post_stall", StallM,    0);
        check("rw_post_rdW",   ReadDataW, 0);
        check("rw_post_wrW",   WriteRegW, 0);
        check("rw_post_jW",    jumpW,     0);
        check("rw_post_pc4W",  PCPlus4W,  0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
